// File: rtl/seg_display_arbiter.sv
// Arbitrates one 4-digit seven-segment display between two requesters with a minimum-hold fairness rule.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN darkens digit slots above the most significant non-zero nibble.
module seg_display_arbiter #(
  parameter int SCAN_DIV    = 100000,
  parameter int HOLD_FRAMES = 250
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [15:0] data0,
  output logic        gnt0,
  input  logic        req1,
  input  logic [15:0] data1,
  output logic        gnt1,
  output logic [3:0]  an,
  output logic [3:0]  digit,
  output logic        blank
);

  localparam int DIV_W  = $clog2(SCAN_DIV);
  localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t              state, state_nxt;
  logic [DIV_W-1:0]    div;
  logic [1:0]          idx;
  logic [HOLD_W-1:0]   hold;
  logic [15:0]         disp;
  logic                last;
  logic                tick, frame_end, hold_full, other_req;

  assign tick      = (div == DIV_W'(SCAN_DIV - 1));
  assign frame_end = tick && (idx == 2'd3);
  assign hold_full = (hold >= HOLD_W'(HOLD_FRAMES - 1));
  assign other_req = (state == OWN0) ? req1 : req0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: a default assignment first keeps this combinational block from inferring latches.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0 && req1) state_nxt = last ? OWN0 : OWN1;
        else if (req0)    state_nxt = OWN0;
        else if (req1)    state_nxt = OWN1;
      end
      OWN0: begin
        if (!req0)                              state_nxt = req1 ? OWN1 : IDLE;
        else if (req1 && frame_end && hold_full) state_nxt = OWN1;
      end
      OWN1: begin
        if (!req1)                              state_nxt = req0 ? OWN0 : IDLE;
        else if (req0 && frame_end && hold_full) state_nxt = OWN0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Scan counters run freely; ownership changes never restart the scan.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div  <= '0;
      idx  <= '0;
      hold <= '0;
      disp <= '0;
      last <= 1'b1;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) idx <= idx + 2'd1;

      if (state_nxt != state)
        hold <= '0;
      else if (state != IDLE && other_req && frame_end && !hold_full)
        hold <= hold + 1'b1;

      // Reload only at grant or frame boundary so a frame never mixes two values.
      if (state_nxt == OWN0 && (state != OWN0 || frame_end)) disp <= data0;
      if (state_nxt == OWN1 && (state != OWN1 || frame_end)) disp <= data1;

      if (state_nxt != state && state_nxt != IDLE) last <= (state_nxt == OWN1);
    end
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [1:0] msd;
  always_comb begin
    msd = 2'd0;
    for (int i = 1; i < 4; i++)
      if (disp[4*i +: 4] != 4'h0) msd = 2'(i);
  end
`endif

  always_comb begin
    gnt0  = (state == OWN0);
    gnt1  = (state == OWN1);
    an    = 4'hF;
    digit = 4'h0;
    blank = 1'b1;
    if (state == OWN0 || state == OWN1) begin
      an    = ~(4'b0001 << idx);
      digit = disp[{idx, 2'b00} +: 4];
      blank = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if (idx > msd) an = 4'hF;
`endif
    end
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench for seg_display_arbiter: directed scenarios then random traffic against a behavioural model.
module tb_seg_display_arbiter;

  localparam int SD = 4;
  localparam int HF = 2;
  localparam int FRAME = 4 * SD;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [15:0] data0 = '0, data1 = '0;
  logic        gnt0, gnt1, blank;
  logic [3:0]  an, digit;

  int total = 0;
  int bad   = 0;

  // Model: owner -1 = nobody; cyc = edges since the last reset edge.
  int          m_owner = -1;
  int          m_cyc   = 0;
  int          m_hold  = 0;
  int          m_last  = 1;
  logic [15:0] m_shown = '0;

  seg_display_arbiter #(.SCAN_DIV(SD), .HOLD_FRAMES(HF)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .data0(data0), .gnt0(gnt0),
    .req1(req1), .data1(data1), .gnt1(gnt1),
    .an(an), .digit(digit), .blank(blank)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    int   nw, o;
    bit   fe;
    bit   r [2];
    logic [15:0] d [2];
    if (!reset) begin
      m_owner = -1; m_cyc = 0; m_hold = 0; m_shown = '0; m_last = 1;
      return;
    end
    r[0] = req0; r[1] = req1; d[0] = data0; d[1] = data1;
    fe = (m_cyc % FRAME) == FRAME - 1;
    if (m_owner < 0) begin
      if (r[0] && r[1]) nw = 1 - m_last;
      else if (r[0])    nw = 0;
      else if (r[1])    nw = 1;
      else              nw = -1;
    end else begin
      o = m_owner;
      if (!r[o])                                nw = r[1-o] ? 1 - o : -1;
      else if (r[1-o] && fe && m_hold >= HF - 1) nw = 1 - o;
      else                                      nw = o;
      if (nw == o && r[1-o] && fe && m_hold < HF - 1) m_hold++;
    end
    if (nw != m_owner) m_hold = 0;
    if (nw >= 0 && (nw != m_owner || fe)) m_shown = d[nw];
    if (nw >= 0 && nw != m_owner) m_last = nw;
    m_owner = nw;
    m_cyc++;
  endtask

  function automatic logic [3:0] exp_an();
    int slot, top;
    logic [3:0] a;
    if (m_owner < 0) return 4'hF;
    slot = (m_cyc / SD) % 4;
    a = ~(4'b0001 << slot);
    top = 0;
    for (int i = 0; i < 4; i++)
      if (m_shown[4*i +: 4] != 4'h0) top = i;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (slot > top) a = 4'hF;
`endif
    return a;
  endfunction

  function automatic logic [3:0] exp_digit();
    int slot;
    if (m_owner < 0) return 4'h0;
    slot = (m_cyc / SD) % 4;
    return m_shown[4*slot +: 4];
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("gnt0",  16'(gnt0),  16'(m_owner == 0));
    check("gnt1",  16'(gnt1),  16'(m_owner == 1));
    check("an",    16'(an),    16'(exp_an()));
    check("digit", 16'(digit), 16'(exp_digit()));
    check("blank", 16'(blank), 16'(m_owner < 0));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    // Reset held with req0 high, then first grant and the anode scan.
    @(negedge clk);
    reset = 1'b0; req0 = 1'b1; data0 = 16'h1234;
    run(3);
    check("rst_gnt0", 16'(gnt0), 16'h0);
    check("rst_an",   16'(an),   16'hF);
    check("rst_blank",16'(blank),16'h1);
    reset = 1'b1;
    cycle();
    check("t1_gnt0", 16'(gnt0), 16'h1);
    check("t1_an_e", 16'(an),   16'hE);
    run(3);  check("t1_an_d", 16'(an), 16'hD);
    run(4);  check("t1_an_b", 16'(an), 16'hB);
    // Switch value mid-frame; reload only at the next frame boundary.
    data0 = 16'h12AB;
    run(4);  check("t1_an_7", 16'(an), 16'h7);
    run(4);  check("t2_d0", 16'(digit), 16'hB);
    run(4);  check("t2_d1", 16'(digit), 16'hA);
    data0 = 16'h3456;
    run(4);  check("t2_d2_old", 16'(digit), 16'h2);
    run(4);  check("t2_d3_old", 16'(digit), 16'h1);
    run(4);  check("t2_d0_new", 16'(digit), 16'h6);

    // Both request from reset: requester 0 first, preempted after the hold.
    reset = 1'b0; req0 = 1'b1; req1 = 1'b1; data1 = 16'hBEEF;
    run(2);
    reset = 1'b1;
    cycle();
    check("t3_gnt0_first", 16'(gnt0), 16'h1);
    run(30);
    check("t3_gnt0_held", 16'(gnt0), 16'h1);
    cycle();
    check("t3_gnt1_pre", 16'(gnt1), 16'h1);
    check("t3_gnt0_pre", 16'(gnt0), 16'h0);

    // Release with the other waiting, then release to idle, then a fresh request.
    req1 = 1'b0;
    cycle();
    check("t4_sw_gnt0", 16'(gnt0), 16'h1);
    req0 = 1'b0;
    cycle();
    check("t4_idle_an",    16'(an),    16'hF);
    check("t4_idle_blank", 16'(blank), 16'h1);
    req1 = 1'b1;
    cycle();
    check("t4_gnt1", 16'(gnt1), 16'h1);

    // Reset during ownership aborts the grant.
    run(5);
    reset = 1'b0;
    cycle();
    check("t6_gnt1",  16'(gnt1),  16'h0);
    check("t6_an",    16'(an),    16'hF);
    check("t6_digit", 16'(digit), 16'h0);
    reset = 1'b1;
    cycle();
    check("t6_regrant", 16'(gnt1), 16'h1);

    // Leading-zero patterns (lit or dark depending on the build).
    req1 = 1'b0; req0 = 1'b1; data0 = 16'h00A0;
    run(20);
    data0 = 16'h0000;
    run(20);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) req0 = ~req0;
      if ($urandom_range(0, 7) == 0) req1 = ~req1;
      if ($urandom_range(0, 3) == 0) data0 = 16'($urandom);
      if ($urandom_range(0, 3) == 0) data1 = 16'($urandom) & {{4{$urandom_range(0,1) == 1}}, 12'hFFF};
      reset = ($urandom_range(0, 299) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
